// File: rtl/tb_data_router.sv
// Routes one OBI-style core data port to N_TGT TCDM-style targets by address and
// hosts a small control region (EXIT/PUTC/CYCLE/CLR), with in-order responses.
module tb_data_router #(
   parameter int unsigned         N_TGT     = 3,
   parameter logic [N_TGT*32-1:0] TGT_BASE  = {32'h1c010000, 32'h00000000, 32'h00100000},
   parameter logic [N_TGT*32-1:0] TGT_MASK  = {32'hff000000, 32'hff100000, 32'h00100000},
   parameter logic [31:0]         CTRL_BASE = 32'h80000000,
   parameter int unsigned         MAX_OUTST = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               core_req_i,
   output logic               core_gnt_o,
   input  logic               core_we_i,
   input  logic [3:0]         core_be_i,
   input  logic [31:0]        core_addr_i,
   input  logic [31:0]        core_wdata_i,
   output logic               core_rvalid_o,
   output logic [31:0]        core_rdata_o,
   input  logic               core_sleep_i,
   output logic [N_TGT-1:0]   tgt_req_o,
   output logic [31:0]        tgt_add_o,
   output logic               tgt_wen_o,
   output logic [3:0]         tgt_be_o,
   output logic [31:0]        tgt_data_o,
   input  logic [N_TGT-1:0]   tgt_gnt_i,
   input  logic [N_TGT-1:0]   tgt_r_valid_i,
   input  logic [N_TGT*32-1:0] tgt_r_data_i,
   output logic               exit_valid_o,
   output logic [31:0]        exit_code_o,
   output logic               putc_valid_o,
   output logic [7:0]         putc_char_o,
   output logic               end_o,
   output logic               unmapped_o,
   output logic               proto_err_o
);

   localparam int unsigned   SW       = $clog2(N_TGT + 1);
   localparam logic [SW-1:0] INT_SLOT = SW'(N_TGT);
   localparam logic [3:0]    MAX_CNT  = 4'(MAX_OUTST);

   logic [N_TGT-1:0] tgt_hit;
   logic             ctrl_hit;
   logic [SW-1:0]    sel;
   logic             sel_gnt;
   logic             stall;
   logic             req_ok;
   logic             hs;
   logic             int_hs;
   logic             ctrl_wr;
   logic [1:0]       ctrl_off;

   logic [SW-1:0]    cur_q;
   logic [3:0]       cnt_q, cnt_d;
   logic             cur_is_int;
   logic             cur_rvalid;
   logic [31:0]      cur_rdata;
   logic [N_TGT-1:0] cur_onehot;
   logic             rsp_valid;
   logic             spurious;

   logic             int_rvalid_q;
   logic [31:0]      int_rdata_q, int_rdata_d;
   logic [31:0]      cycle_q;
   logic [31:0]      exit_code_q;
   logic             exit_valid_q;
   logic             exit_written_q;
   logic             putc_valid_q;
   logic [7:0]       putc_char_q;
   logic             end_q;
   logic             unmapped_q;
   logic             proto_err_q;

   // Target 0 is the leftmost entry of the packed base/mask lists.
   for (genvar g = 0; g < N_TGT; g++) begin : g_dec
      localparam int unsigned IDX = N_TGT - 1 - g;
      assign tgt_hit[g] = (core_addr_i & TGT_MASK[IDX*32 +: 32]) ==
                          (TGT_BASE[IDX*32 +: 32] & TGT_MASK[IDX*32 +: 32]);
   end

   assign ctrl_hit = (core_addr_i[31:4] == CTRL_BASE[31:4]);
   assign ctrl_off = core_addr_i[3:2];

   always_comb begin
      sel = INT_SLOT;
      for (int k = N_TGT - 1; k >= 0; k--) begin
         if (tgt_hit[k]) sel = SW'(k);
      end
      if (ctrl_hit) sel = INT_SLOT;
   end

   always_comb begin
      sel_gnt = 1'b1;
      for (int k = 0; k < N_TGT; k++) begin
         if (sel == SW'(k)) sel_gnt = tgt_gnt_i[k];
      end
   end

   // A new access may only join outstanding ones going to the same slot.
   assign stall  = (cnt_q == MAX_CNT) | ((cnt_q != 4'd0) & (sel != cur_q));
   assign req_ok = core_req_i & ~stall;
   assign core_gnt_o = req_ok & sel_gnt;
   assign hs      = core_req_i & core_gnt_o;
   assign int_hs  = hs & (sel == INT_SLOT);
   assign ctrl_wr = int_hs & ctrl_hit & core_we_i;

   always_comb begin
      tgt_req_o = '0;
      for (int k = 0; k < N_TGT; k++) begin
         tgt_req_o[k] = req_ok & (sel == SW'(k));
      end
   end

   assign tgt_add_o  = core_addr_i;
   assign tgt_wen_o  = ~core_we_i;
   assign tgt_be_o   = core_be_i;
   assign tgt_data_o = core_wdata_i;

   always_comb begin
      cur_rvalid = 1'b0;
      cur_rdata  = '0;
      cur_onehot = '0;
      for (int k = 0; k < N_TGT; k++) begin
         if (cur_q == SW'(k)) begin
            cur_onehot[k] = 1'b1;
            cur_rvalid    = tgt_r_valid_i[k];
            cur_rdata     = tgt_r_data_i[k*32 +: 32];
         end
      end
   end

   assign cur_is_int = (cur_q == INT_SLOT);
   assign rsp_valid  = (cnt_q != 4'd0) & (cur_is_int ? int_rvalid_q : cur_rvalid);
   assign spurious   = (cnt_q == 4'd0) ? (|tgt_r_valid_i) : (|(tgt_r_valid_i & ~cur_onehot));

   assign core_rvalid_o = rsp_valid;
   assign core_rdata_o  = rsp_valid ? (cur_is_int ? int_rdata_q : cur_rdata) : 32'd0;

   always_comb begin
      cnt_d = cnt_q;
      if (hs && !rsp_valid)      cnt_d = cnt_q + 4'd1;
      else if (!hs && rsp_valid) cnt_d = cnt_q - 4'd1;
   end

   // Unmapped reads and all writes answer with zero data.
   always_comb begin
      int_rdata_d = '0;
      if (ctrl_hit && !core_we_i) begin
         case (ctrl_off)
            2'd0:    int_rdata_d = exit_code_q;
            2'd2:    int_rdata_d = cycle_q;
            default: int_rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q          <= '0;
         cur_q          <= '0;
         int_rvalid_q   <= 1'b0;
         int_rdata_q    <= '0;
         cycle_q        <= '0;
         exit_code_q    <= 32'hFFFF_FFFF;
         exit_valid_q   <= 1'b0;
         exit_written_q <= 1'b0;
         putc_valid_q   <= 1'b0;
         putc_char_q    <= '0;
         end_q          <= 1'b0;
         unmapped_q     <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         if (hs) cur_q <= sel;
         int_rvalid_q <= int_hs;
         if (int_hs) int_rdata_q <= int_rdata_d;
         cycle_q      <= (ctrl_wr && ctrl_off == 2'd3) ? 32'd0 : cycle_q + 32'd1;
         exit_valid_q <= ctrl_wr && ctrl_off == 2'd0;
         putc_valid_q <= ctrl_wr && ctrl_off == 2'd1;
         if (ctrl_wr && ctrl_off == 2'd0) begin
            exit_code_q    <= core_wdata_i;
            exit_written_q <= 1'b1;
         end
         if (ctrl_wr && ctrl_off == 2'd1) putc_char_q <= core_wdata_i[7:0];
         end_q        <= exit_written_q & core_sleep_i;
         unmapped_q   <= unmapped_q | (int_hs & ~ctrl_hit);
         proto_err_q  <= proto_err_q | spurious;
      end
   end

   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;
   assign putc_valid_o = putc_valid_q;
   assign putc_char_o  = putc_char_q;
   assign end_o        = end_q;
   assign unmapped_o   = unmapped_q;
   assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_tb_data_router.sv
// Directed bench for tb_data_router: decode, stalls, ordering, control registers, errors.
module tb_tb_data_router;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_req_i, core_we_i, core_sleep_i;
   logic [3:0]  core_be_i;
   logic [31:0] core_addr_i, core_wdata_i;
   logic        core_gnt_o, core_rvalid_o;
   logic [31:0] core_rdata_o;
   logic [2:0]  tgt_req_o, tgt_gnt_i, tgt_r_valid_i;
   logic [31:0] tgt_add_o, tgt_data_o;
   logic        tgt_wen_o;
   logic [3:0]  tgt_be_o;
   logic [95:0] tgt_r_data_i;
   logic        exit_valid_o, putc_valid_o, end_o, unmapped_o, proto_err_o;
   logic [31:0] exit_code_o;
   logic [7:0]  putc_char_o;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   tb_data_router dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
      .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_sleep_i(core_sleep_i),
      .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
      .tgt_be_o(tgt_be_o), .tgt_data_o(tgt_data_o), .tgt_gnt_i(tgt_gnt_i),
      .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_data_i(tgt_r_data_i),
      .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o),
      .putc_valid_o(putc_valid_o), .putc_char_o(putc_char_o),
      .end_o(end_o), .unmapped_o(unmapped_o), .proto_err_o(proto_err_o)
   );

   // Clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic idle();
      core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'hF;
      core_addr_i = '0; core_wdata_i = '0;
      tgt_gnt_i = 3'b111; tgt_r_valid_i = '0; tgt_r_data_i = '0;
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      core_req_i = 1'b1; core_we_i = we; core_addr_i = addr; core_wdata_i = wdata;
   endtask

   task automatic apply_reset();
      @(negedge clk_i); rst_ni = 1'b0; idle();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b1; idle(); core_sleep_i = 1'b0;
      #2 rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      n_total++; if (core_gnt_o !== 1'b0) $display("FAIL rst_gnt: got %b exp 0", core_gnt_o); else n_pass++;
      n_total++; if (core_rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", core_rvalid_o); else n_pass++;
      n_total++; if (core_rdata_o !== 32'd0) $display("FAIL rst_rdata: got %h exp 0", core_rdata_o); else n_pass++;
      n_total++; if (tgt_req_o !== 3'b000) $display("FAIL rst_tgt_req: got %b exp 000", tgt_req_o); else n_pass++;
      n_total++; if (exit_code_o !== 32'hFFFF_FFFF) $display("FAIL rst_exit_code: got %h exp ffffffff", exit_code_o); else n_pass++;
      n_total++; if ({exit_valid_o, putc_valid_o, end_o, unmapped_o, proto_err_o} !== 5'b0)
         $display("FAIL rst_flags: got %b exp 00000", {exit_valid_o, putc_valid_o, end_o, unmapped_o, proto_err_o}); else n_pass++;
      n_total++; if (putc_char_o !== 8'd0) $display("FAIL rst_putc_char: got %h exp 00", putc_char_o); else n_pass++;
      @(negedge clk_i); rst_ni = 1'b1;
   endtask

   task automatic test_decode();
      logic [31:0] addrs[4];
      logic [2:0]  reqs[4];
      addrs = '{32'h1c010000, 32'h00000010, 32'h00100000, 32'h1c100000};
      reqs  = '{3'b001, 3'b010, 3'b100, 3'b001};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         idle(); tgt_gnt_i = 3'b000; drive(1'b0, addrs[i], '0);
         #1;
         n_total++; if (tgt_req_o !== reqs[i]) $display("FAIL decode_%0d: got %b exp %b", i, tgt_req_o, reqs[i]); else n_pass++;
         n_total++; if (core_gnt_o !== 1'b0) $display("FAIL decode_nognt_%0d: got %b exp 0", i, core_gnt_o); else n_pass++;
      end
      @(negedge clk_i); idle();
   endtask

   task automatic test_single_read();
      @(negedge clk_i); idle(); drive(1'b0, 32'h1c010000, '0);
      #1;
      n_total++; if (core_gnt_o !== 1'b1) $display("FAIL rd_gnt: got %b exp 1", core_gnt_o); else n_pass++;
      n_total++; if ({tgt_req_o, tgt_wen_o, tgt_add_o} !== {3'b001, 1'b1, 32'h1c010000})
         $display("FAIL rd_bcast: got %b/%b/%h exp 001/1/1c010000", tgt_req_o, tgt_wen_o, tgt_add_o); else n_pass++;
      @(negedge clk_i); idle(); tgt_r_valid_i = 3'b001; tgt_r_data_i[31:0] = 32'hCAFEF00D;
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hCAFEF00D})
         $display("FAIL rd_rsp: got %b/%h exp 1/cafef00d", core_rvalid_o, core_rdata_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if (core_rvalid_o !== 1'b0) $display("FAIL rd_rsp_end: got %b exp 0", core_rvalid_o); else n_pass++;
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(32'h11111111);
      exp_q.push_back(32'h22222222);
      @(negedge clk_i); idle(); drive(1'b0, 32'h1c010004, '0);
      #1;
      n_total++; if (core_gnt_o !== 1'b1) $display("FAIL b2b_gnt0: got %b exp 1", core_gnt_o); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i); drive(1'b0, 32'h00000010, '0);
         #1;
         n_total++; if ({core_gnt_o, tgt_req_o} !== 4'b0000)
            $display("FAIL b2b_stall_%0d: got %b/%b exp 0/000", i, core_gnt_o, tgt_req_o); else n_pass++;
      end
      @(negedge clk_i); tgt_r_valid_i = 3'b001; tgt_r_data_i[31:0] = 32'h11111111;
      #1;
      exp_v = exp_q.pop_front();
      n_total++; if ({core_rvalid_o, core_rdata_o, core_gnt_o} !== {1'b1, exp_v, 1'b0})
         $display("FAIL b2b_rsp0: got %b/%h/%b exp 1/%h/0", core_rvalid_o, core_rdata_o, core_gnt_o, exp_v); else n_pass++;
      @(negedge clk_i); tgt_r_valid_i = 3'b000;
      #1;
      n_total++; if ({core_gnt_o, tgt_req_o} !== 4'b1010)
         $display("FAIL b2b_gnt1: got %b/%b exp 1/010", core_gnt_o, tgt_req_o); else n_pass++;
      @(negedge clk_i); idle(); tgt_r_valid_i = 3'b010; tgt_r_data_i[63:32] = 32'h22222222;
      #1;
      exp_v = exp_q.pop_front();
      n_total++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, exp_v})
         $display("FAIL b2b_rsp1: got %b/%h exp 1/%h", core_rvalid_o, core_rdata_o, exp_v); else n_pass++;
      @(negedge clk_i); idle();
   endtask

   task automatic test_max_outst();
      logic [2:0] gnts[4];
      gnts = '{3'b1, 3'b1, 3'b0, 3'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i); idle(); drive(1'b0, 32'h1c010008, '0);
         #1;
         n_total++; if (core_gnt_o !== gnts[i][0]) $display("FAIL outst_gnt_%0d: got %b exp %b", i, core_gnt_o, gnts[i][0]); else n_pass++;
      end
      @(negedge clk_i); tgt_r_valid_i = 3'b001; tgt_r_data_i[31:0] = 32'h0000000A;
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o, core_gnt_o} !== {1'b1, 32'h0A, 1'b0})
         $display("FAIL outst_rsp_a: got %b/%h/%b exp 1/0000000a/0", core_rvalid_o, core_rdata_o, core_gnt_o); else n_pass++;
      @(negedge clk_i); tgt_r_data_i[31:0] = 32'h0000000B;
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o, core_gnt_o} !== {1'b1, 32'h0B, 1'b1})
         $display("FAIL outst_rsp_b: got %b/%h/%b exp 1/0000000b/1", core_rvalid_o, core_rdata_o, core_gnt_o); else n_pass++;
      @(negedge clk_i); core_req_i = 1'b0; tgt_r_data_i[31:0] = 32'h0000000C;
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'h0C})
         $display("FAIL outst_rsp_c: got %b/%h exp 1/0000000c", core_rvalid_o, core_rdata_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if ({core_rvalid_o, proto_err_o} !== 2'b00)
         $display("FAIL outst_done: got %b/%b exp 0/0", core_rvalid_o, proto_err_o); else n_pass++;
   endtask

   task automatic test_ctrl();
      @(negedge clk_i); idle(); drive(1'b1, 32'h80000004, 32'h00000041);
      #1;
      n_total++; if ({core_gnt_o, tgt_req_o} !== 4'b1000) $display("FAIL putc_gnt: got %b/%b exp 1/000", core_gnt_o, tgt_req_o); else n_pass++;
      @(negedge clk_i); drive(1'b1, 32'h80000000, 32'h00000000);
      #1;
      n_total++; if ({putc_valid_o, putc_char_o, core_rvalid_o, core_gnt_o} !== {1'b1, 8'h41, 1'b1, 1'b1})
         $display("FAIL putc_pulse: got %b/%h/%b/%b exp 1/41/1/1", putc_valid_o, putc_char_o, core_rvalid_o, core_gnt_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if ({exit_valid_o, exit_code_o, putc_valid_o, core_rvalid_o} !== {1'b1, 32'd0, 1'b0, 1'b1})
         $display("FAIL exit_pulse: got %b/%h/%b/%b exp 1/00000000/0/1", exit_valid_o, exit_code_o, putc_valid_o, core_rvalid_o); else n_pass++;
      @(negedge clk_i); core_sleep_i = 1'b1;
      #1;
      n_total++; if ({exit_valid_o, end_o, core_rvalid_o} !== 3'b000)
         $display("FAIL exit_idle: got %b/%b/%b exp 0/0/0", exit_valid_o, end_o, core_rvalid_o); else n_pass++;
      @(negedge clk_i); core_sleep_i = 1'b0;
      #1;
      n_total++; if (end_o !== 1'b1) $display("FAIL end_high: got %b exp 1", end_o); else n_pass++;
      @(negedge clk_i);
      #1;
      n_total++; if (end_o !== 1'b0) $display("FAIL end_drop: got %b exp 0", end_o); else n_pass++;
   endtask

   task automatic test_spurious();
      @(negedge clk_i); idle(); tgt_r_valid_i = 3'b100; tgt_r_data_i[95:64] = 32'hDEADBEEF;
      #1;
      n_total++; if ({core_rvalid_o, proto_err_o} !== 2'b00)
         $display("FAIL spur_drop: got %b/%b exp 0/0", core_rvalid_o, proto_err_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if ({core_rvalid_o, proto_err_o} !== 2'b01)
         $display("FAIL spur_err: got %b/%b exp 0/1", core_rvalid_o, proto_err_o); else n_pass++;
   endtask

   task automatic test_cycle_unmapped();
      apply_reset();
      repeat (100) @(negedge clk_i);
      drive(1'b0, 32'h80000008, '0);
      @(negedge clk_i); idle();
      #1;
      n_total++; if ((core_rvalid_o === 1'b1 && core_rdata_o >= 32'd99 && core_rdata_o <= 32'd101) !== 1'b1)
         $display("FAIL cycle_100: got %b/%0d exp 1/~100", core_rvalid_o, core_rdata_o); else n_pass++;
      @(negedge clk_i); drive(1'b1, 32'h8000000C, 32'h12345678);
      @(negedge clk_i); drive(1'b0, 32'h80000008, '0);
      @(negedge clk_i); drive(1'b0, 32'h80000000, '0);
      #1;
      n_total++; if ((core_rvalid_o === 1'b1 && core_rdata_o <= 32'd3) !== 1'b1)
         $display("FAIL cycle_clr: got %b/%0d exp 1/<=3", core_rvalid_o, core_rdata_o); else n_pass++;
      @(negedge clk_i); drive(1'b0, 32'h40000000, '0);
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o} !== {1'b1, 32'hFFFF_FFFF})
         $display("FAIL exit_read: got %b/%h exp 1/ffffffff", core_rvalid_o, core_rdata_o); else n_pass++;
      n_total++; if ({core_gnt_o, unmapped_o} !== 2'b10)
         $display("FAIL unmap_gnt: got %b/%b exp 1/0", core_gnt_o, unmapped_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if ({core_rvalid_o, core_rdata_o, unmapped_o} !== {1'b1, 32'd0, 1'b1})
         $display("FAIL unmap_rsp: got %b/%h/%b exp 1/00000000/1", core_rvalid_o, core_rdata_o, unmapped_o); else n_pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i); idle(); drive(1'b0, 32'h1c010000, '0);
      @(negedge clk_i); idle(); rst_ni = 1'b0;
      #1;
      n_total++; if ({core_rvalid_o, unmapped_o, proto_err_o, end_o, tgt_req_o} !== 7'b0)
         $display("FAIL mid_rst_flags: got %b/%b/%b/%b/%b exp all 0", core_rvalid_o, unmapped_o, proto_err_o, end_o, tgt_req_o); else n_pass++;
      n_total++; if (exit_code_o !== 32'hFFFF_FFFF) $display("FAIL mid_rst_exit: got %h exp ffffffff", exit_code_o); else n_pass++;
      @(negedge clk_i); rst_ni = 1'b1;
      @(negedge clk_i); tgt_r_valid_i = 3'b001; tgt_r_data_i[31:0] = 32'h55555555;
      #1;
      n_total++; if (core_rvalid_o !== 1'b0) $display("FAIL mid_late_rvalid: got %b exp 0", core_rvalid_o); else n_pass++;
      @(negedge clk_i); idle();
      #1;
      n_total++; if (proto_err_o !== 1'b1) $display("FAIL mid_late_err: got %b exp 1", proto_err_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_single_read();
      test_back_to_back();
      test_max_outst();
      test_ctrl();
      test_spurious();
      test_cycle_unmapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
